// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared types and sizing helpers for configuration-chain loading
package fpga_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FLUSH
  } load_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int words_per_load(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - load word stream and readback word stream of the chain loader
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [WORD_W-1:0] wr_data;
  logic              rb_valid;
  logic              rb_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_last;

  modport master (
    output wr_valid, wr_data, rb_ready,
    input  wr_ready, rb_valid, rb_data, rb_last
  );

  modport slave (
    input  wr_valid, wr_data, rb_ready,
    output wr_ready, rb_valid, rb_data, rb_last
  );
endinterface

// File: rtl/ccff_rb_packer.sv
// rtl/ccff_rb_packer.sv - packs chain tail bits MSB-first into readback words
module ccff_rb_packer
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample,
  input  logic              tail,
  input  logic              final_bit,
  input  logic              flush,
  input  logic              rb_ready,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_last,
  output logic              stall_next
);
  localparam int ACNT_W = cnt_width(WORD_W);

  logic [WORD_W-1:0] asm_data, asm_data_n, data_n;
  logic [ACNT_W-1:0] asm_cnt, asm_cnt_n;
  logic              valid_n, last_n, out_free, move, move_last;

  always_comb begin
    asm_data_n = asm_data;
    asm_cnt_n  = asm_cnt;
    data_n     = rb_data;
    valid_n    = rb_valid;
    last_n     = rb_last;
    move       = 1'b0;
    move_last  = 1'b0;
    out_free   = !rb_valid || rb_ready;
    if (rb_valid && rb_ready) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
    end
    if (sample) begin
      asm_data_n = (asm_data << 1) | WORD_W'(tail);
      asm_cnt_n  = asm_cnt + ACNT_W'(1);
    end
    if (asm_cnt_n == ACNT_W'(WORD_W) && out_free) begin
      move      = 1'b1;
      move_last = final_bit || flush;
    end else if (flush && asm_cnt != '0 && out_free) begin
      move      = 1'b1;
      move_last = 1'b1;
    end
    // A partial final word is left-justified so its LSBs read back as zero.
    if (move) begin
      data_n     = asm_data_n << (ACNT_W'(WORD_W) - asm_cnt_n);
      valid_n    = 1'b1;
      last_n     = move_last;
      asm_data_n = '0;
      asm_cnt_n  = '0;
    end
    stall_next = (asm_cnt_n == ACNT_W'(WORD_W)) && valid_n;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      asm_data <= '0;
      asm_cnt  <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
      rb_last  <= 1'b0;
    end else begin
      asm_data <= asm_data_n;
      asm_cnt  <= asm_cnt_n;
      rb_data  <= data_n;
      rb_valid <= valid_n;
      rb_last  <= last_n;
    end
  end
endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes load words into a configuration chain and returns readback
module ccff_chain_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  ccff_chain_loader_if.slave  bus,
  output logic                shift_en,
  output logic                ccff_head,
  input  logic                ccff_tail
);
  localparam int CNT_W     = cnt_width(CHAIN_LEN);
  localparam int NWORDS    = words_per_load(CHAIN_LEN, WORD_W);
  localparam int WCNT_W    = cnt_width(NWORDS);
  localparam int BCNT_W    = cnt_width(WORD_W);
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;

  load_state_t       state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [WCNT_W-1:0] word_cnt, word_cnt_n;
  logic [WORD_W-1:0] buf_data, buf_data_n;
  logic [BCNT_W-1:0] buf_cnt, buf_cnt_n;
  logic shift_en_n, head_n, busy_n, done_n;
  logic wr_ready_c, accept, launch, final_bit, rb_done, in_flush, stall_next;

  assign launch     = (state == ST_IDLE) && start;
  assign in_flush   = (state == ST_FLUSH);
  assign final_bit  = shift_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign rb_done    = in_flush && bus.rb_valid && bus.rb_ready && bus.rb_last;
  // Ready as soon as the buffer will be empty after this edge, so words overlap without a bubble.
  assign wr_ready_c = (state == ST_SHIFT) && (word_cnt < WCNT_W'(NWORDS)) &&
                      (buf_cnt == '0 || (buf_cnt == BCNT_W'(1) && shift_en));
  assign accept       = bus.wr_valid && wr_ready_c;
  assign bus.wr_ready = wr_ready_c;

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    buf_data_n = buf_data;
    buf_cnt_n  = buf_cnt;
    if (shift_en) begin
      buf_data_n = buf_data << 1;
      buf_cnt_n  = buf_cnt - BCNT_W'(1);
      bit_cnt_n  = bit_cnt + CNT_W'(1);
    end
    if (accept) begin
      buf_data_n = bus.wr_data;
      buf_cnt_n  = (word_cnt == WCNT_W'(NWORDS - 1)) ? BCNT_W'(LAST_BITS) : BCNT_W'(WORD_W);
      word_cnt_n = word_cnt + WCNT_W'(1);
    end
    case (state)
      ST_IDLE: if (start) begin
        state_n    = ST_SHIFT;
        bit_cnt_n  = '0;
        word_cnt_n = '0;
        buf_cnt_n  = '0;
      end
      ST_SHIFT: if (final_bit) state_n = ST_FLUSH;
      ST_FLUSH: if (rb_done) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    // shift_en is a flop, so the shift decision is made on next-cycle state.
    shift_en_n = (state_n == ST_SHIFT) && (buf_cnt_n != '0) && !stall_next;
    head_n     = shift_en_n && buf_data_n[WORD_W-1];
    busy_n     = (state_n != ST_IDLE);
    done_n     = rb_done;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      buf_data  <= '0;
      buf_cnt   <= '0;
      shift_en  <= 1'b0;
      ccff_head <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      word_cnt  <= word_cnt_n;
      buf_data  <= buf_data_n;
      buf_cnt   <= buf_cnt_n;
      shift_en  <= shift_en_n;
      ccff_head <= head_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  ccff_rb_packer #(.WORD_W(WORD_W)) u_packer (
    .clk        (prog_clk),
    .rst        (prog_reset),
    .clear      (launch),
    .sample     (shift_en),
    .tail       (ccff_tail),
    .final_bit  (final_bit),
    .flush      (in_flush),
    .rb_ready   (bus.rb_ready),
    .rb_valid   (bus.rb_valid),
    .rb_data    (bus.rb_data),
    .rb_last    (bus.rb_last),
    .stall_next (stall_next)
  );
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench driving a 12-flop and a 24-flop chain model
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel, wv, rr, st_s, st_b;
  logic [7:0] wd;
  logic       busy_s, done_s, se_s, head_s, busy_b, done_b, se_b, head_b;
  logic [11:0] chain_s = '0;
  logic [23:0] chain_b = '0;

  ccff_chain_loader_if #(.WORD_W(8)) s_if ();
  ccff_chain_loader_if #(.WORD_W(8)) b_if ();

  assign s_if.wr_valid = wv && !sel;
  assign s_if.wr_data  = wd;
  assign s_if.rb_ready = rr;
  assign b_if.wr_valid = wv && sel;
  assign b_if.wr_data  = wd;
  assign b_if.rb_ready = rr;

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_s (
    .prog_clk(clk), .prog_reset(rst), .start(st_s), .busy(busy_s), .done(done_s),
    .bus(s_if), .shift_en(se_s), .ccff_head(head_s), .ccff_tail(chain_s[11]));

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut_b (
    .prog_clk(clk), .prog_reset(rst), .start(st_b), .busy(busy_b), .done(done_b),
    .bus(b_if), .shift_en(se_b), .ccff_head(head_b), .ccff_tail(chain_b[23]));

  int pc_s = 0, pc_b = 0, dc_s = 0, dc_b = 0, n_s = 0, n_b = 0, bad = 0;
  logic [8:0] log_s [16];
  logic [8:0] log_b [16];

  always @(posedge clk) begin
    if (se_s) begin chain_s <= {chain_s[10:0], head_s}; pc_s <= pc_s + 1; end
    if (se_b) begin chain_b <= {chain_b[22:0], head_b}; pc_b <= pc_b + 1; end
    if (s_if.rb_valid && s_if.rb_ready) begin
      log_s[n_s[3:0]] <= {s_if.rb_last, s_if.rb_data}; n_s <= n_s + 1;
    end
    if (b_if.rb_valid && b_if.rb_ready) begin
      log_b[n_b[3:0]] <= {b_if.rb_last, b_if.rb_data}; n_b <= n_b + 1;
    end
    if (done_s) dc_s <= dc_s + 1;
    if (done_b) dc_b <= dc_b + 1;
    if ((se_s && !busy_s) || (se_b && !busy_b)) bad <= bad + 1;
  end

  wire wr_rdy = sel ? b_if.wr_ready : s_if.wr_ready;
  wire dn     = sel ? done_b : done_s;

  function automatic int pulses();          return sel ? pc_b : pc_s; endfunction
  function automatic int rbn();             return sel ? n_b : n_s;   endfunction
  function automatic int dones();           return sel ? dc_b : dc_s; endfunction
  function automatic logic [8:0] rb_at(input int i);
    return sel ? log_b[i[3:0]] : log_s[i[3:0]];
  endfunction
  function automatic logic [23:0] chain();  return sel ? chain_b : {12'h000, chain_s}; endfunction

  int n_chk = 0, n_err = 0;
  int p0, r0, d0, pr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_case();
    p0 = pulses(); r0 = rbn(); d0 = dones();
  endtask

  task automatic start_load();
    if (sel) st_b = 1'b1; else st_s = 1'b1;
    tick();
    st_s = 1'b0; st_b = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    wv = 1'b1; wd = d;
    @(negedge clk);
    while (!wr_rdy && t < 200) begin @(negedge clk); t++; end
    chk("wr_accept", wr_rdy, 1);
    tick();
    wv = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!dn && t < 500) begin @(negedge clk); t++; end
    chk("done_seen", dn, 1);
    tick(); tick();
  endtask

  task automatic verify(input string tag, input int np, input logic [23:0] ch, input int nrb,
                        input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
    chk({tag, "_pulses"}, pulses() - p0, np);
    chk({tag, "_chain"}, chain(), ch);
    chk({tag, "_rb_count"}, rbn() - r0, nrb);
    chk({tag, "_rb0"}, rb_at(r0), e0);
    chk({tag, "_rb1"}, rb_at(r0 + 1), e1);
    if (nrb == 3) chk({tag, "_rb2"}, rb_at(r0 + 2), e2);
    chk({tag, "_done"}, dones() - d0, 1);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; wv = 1'b0; wd = '0; rr = 1'b1; st_s = 1'b0; st_b = 1'b0;
    repeat (3) tick();
    chk("rst_busy_done", {busy_s, done_s, busy_b, done_b}, 0);
    chk("rst_wr_ready", {s_if.wr_ready, b_if.wr_ready}, 0);
    chk("rst_shift_head", {se_s, head_s, se_b, head_b}, 0);
    chk("rst_rb_s", {s_if.rb_valid, s_if.rb_last, s_if.rb_data}, 0);
    chk("rst_rb_b", {b_if.rb_valid, b_if.rb_last, b_if.rb_data}, 0);
    rst = 1'b0;
    tick();

    // basic load into an all-zero chain
    begin_case();
    start_load();
    chk("start_busy", busy_s, 1);
    chk("start_wr_ready", s_if.wr_ready, 1);
    send(8'hA5); send(8'h3F);
    wait_done();
    verify("basic", 12, 24'h000A53, 2, 9'h000, 9'h100, 9'h000);
    chk("idle_after_done", {busy_s, se_s}, 0);

    // reload reads back the previous stream
    begin_case();
    start_load();
    send(8'hFF); send(8'hF0);
    wait_done();
    verify("reload", 12, 24'h000FFF, 2, 9'h0A5, 9'h130, 9'h000);

    // gap in wr_valid after the first word drains
    begin_case();
    start_load();
    send(8'h5A);
    repeat (8) tick();
    chk("gap_first_word", pulses() - p0, 8);
    pr = pulses();
    repeat (5) tick();
    chk("gap_no_shift", pulses() - pr, 0);
    chk("gap_shift_low", se_s, 0);
    send(8'hC0);
    wait_done();
    verify("gapped", 12, 24'h0005AC, 2, 9'h0FF, 9'h1F0, 9'h000);

    // start pulsed mid-shift is ignored
    begin_case();
    start_load();
    send(8'h12);
    st_s = 1'b1; tick(); st_s = 1'b0;
    send(8'h34);
    wait_done();
    verify("start_in_shift", 12, 24'h000123, 2, 9'h05A, 9'h1C0, 9'h000);

    // reset after 5 pulses, then a full reload
    begin_case();
    start_load();
    wv = 1'b1; wd = 8'hE7;
    begin
      int t = 0;
      @(negedge clk);
      while ((pulses() - p0) < 5 && t < 100) begin @(negedge clk); t++; end
      chk("mid_reset_reached", (pulses() - p0) >= 5, 1);
    end
    rst = 1'b1; wv = 1'b0;
    tick();
    chk("mid_reset_ctrl", {busy_s, done_s, s_if.wr_ready, se_s, head_s}, 0);
    chk("mid_reset_rb", {s_if.rb_valid, s_if.rb_last, s_if.rb_data}, 0);
    pr = pulses();
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("mid_reset_no_shift", pulses() - pr, 0);
    begin_case();
    start_load();
    send(8'h96); send(8'h50);
    wait_done();
    chk("after_reset_pulses", pulses() - p0, 12);
    chk("after_reset_chain", chain_s, 12'h965);
    chk("after_reset_done", dones() - d0, 1);

    // 24-flop chain: fill, then reload under readback backpressure
    sel = 1'b1;
    begin_case();
    start_load();
    send(8'h11); send(8'h22); send(8'h33);
    wait_done();
    verify("bp_fill", 24, 24'h112233, 3, 9'h000, 9'h000, 9'h100);
    begin_case();
    rr = 1'b0;
    start_load();
    send(8'h44); send(8'h55); send(8'h66);
    repeat (20) tick();
    chk("bp_stall_pulses", pulses() - p0, 16);
    chk("bp_rb_held", {b_if.rb_valid, b_if.rb_data}, 9'h111);
    chk("bp_no_handshake", rbn() - r0, 0);
    chk("bp_shift_low", se_b, 0);
    rr = 1'b1;
    wait_done();
    verify("bp_resume", 24, 24'h445566, 3, 9'h011, 9'h022, 9'h133);

    chk("no_shift_while_idle", bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
